// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Each digit gets a slot of CLK_DIV clocks. The first GUARD clocks of every
// slot keep all anodes off so that segment data settles before the next digit
// lights (this avoids ghosting). New data is captured into a shadow register
// and moved to the display register only on a frame boundary. A frame
// therefore never mixes old and new digits.
//
// Ports
//   clk        : single clock; state changes on its rising edge
//   rst_n      : asynchronous active-low reset
//   load       : capture digits/dp_in/blank this cycle
//   digits     : four hex nibbles, [3:0] is digit 0 (rightmost)
//   dp_in      : decimal point request per digit, 1 = on
//   blank      : digit suppress per digit, 1 = dark
//   seg[0:6]   : segment cathodes a..g, active-low
//   an         : digit anodes, active-low, an[i] selects digit i
//   dp         : decimal point cathode, active-low
//   frame_done : one-cycle pulse on the last cycle of each frame
// ---------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int CLK_DIV = 4,
  parameter int GUARD   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank,
  output logic [0:6]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_count;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadowDigits;
  logic [3:0]    r_shadowDp;
  logic [3:0]    r_shadowBlank;
  logic          r_pending;
  logic [15:0]   r_dispDigits;
  logic [3:0]    r_dispDp;
  logic [3:0]    r_dispBlank;

  logic          w_slotTick;
  logic          w_frameDone;
  logic [3:0]    w_nibble;
  logic          w_dark;
  logic [0:6]    w_segDecoded;

  assign w_slotTick  = (r_count == CW'(CLK_DIV - 1));
  assign w_frameDone = w_slotTick && (r_idx == 2'd3);

  // Prescaler and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_idx   <= 2'd0;
    end else if (w_slotTick) begin
      r_count <= '0;
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  // Shadow/display double buffer. A load on the frame boundary itself goes
  // straight to the display, so nothing is left pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadowDigits <= '0;
      r_shadowDp     <= '0;
      r_shadowBlank  <= '0;
      r_pending      <= 1'b0;
      r_dispDigits   <= '0;
      r_dispDp       <= '0;
      r_dispBlank    <= '0;
    end else begin
      if (load) begin
        r_shadowDigits <= digits;
        r_shadowDp     <= dp_in;
        r_shadowBlank  <= blank;
      end
      if (w_frameDone) begin
        r_pending <= 1'b0;
        if (load) begin
          r_dispDigits <= digits;
          r_dispDp     <= dp_in;
          r_dispBlank  <= blank;
        end else if (r_pending) begin
          r_dispDigits <= r_shadowDigits;
          r_dispDp     <= r_shadowDp;
          r_dispBlank  <= r_shadowBlank;
        end
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign w_nibble = r_dispDigits[{r_idx, 2'b00} +: 4];

  // Hex to active-low segments, seg[0] = a ... seg[6] = g.
  always_comb begin
    w_segDecoded = 7'b1111111;
    case (w_nibble)
      4'h0: w_segDecoded = 7'b0000001;
      4'h1: w_segDecoded = 7'b1001111;
      4'h2: w_segDecoded = 7'b0010010;
      4'h3: w_segDecoded = 7'b0000110;
      4'h4: w_segDecoded = 7'b1001100;
      4'h5: w_segDecoded = 7'b0100100;
      4'h6: w_segDecoded = 7'b0100000;
      4'h7: w_segDecoded = 7'b0001111;
      4'h8: w_segDecoded = 7'b0000000;
      4'h9: w_segDecoded = 7'b0000100;
      4'hA: w_segDecoded = 7'b0001000;
      4'hB: w_segDecoded = 7'b1100000;
      4'hC: w_segDecoded = 7'b0110001;
      4'hD: w_segDecoded = 7'b1000010;
      4'hE: w_segDecoded = 7'b0110000;
      4'hF: w_segDecoded = 7'b0111000;
      default: w_segDecoded = 7'b1111111;
    endcase
  end

  // rst_n is included so the display is dark during reset even when GUARD = 0.
  assign w_dark = !rst_n || (int'(r_count) < GUARD) || r_dispBlank[r_idx];

  always_comb begin
    an  = 4'b1111;
    seg = 7'b1111111;
    dp  = 1'b1;
    if (!w_dark) begin
      an  = ~(4'b0001 << r_idx);
      seg = w_segDecoded;
      dp  = ~r_dispDp[r_idx];
    end
  end

  assign frame_done = w_frameDone && rst_n;

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving clock cycles per digit slot (≥2).
REQ-002 The block SHALL have parameter GUARD, default 1, giving the anode-off cycles at the start of each slot (0 ≤ GUARD < CLK_DIV).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port load, input, 1 bit: when high, capture digits/dp_in/blank this cycle.
REQ-006 The block SHALL have port digits, input, 16 bits: four hex nibbles; [3:0] is digit 0 (rightmost).
REQ-007 The block SHALL have port dp_in, input, 4 bits: decimal point request per digit, 1 = on.
REQ-008 The block SHALL have port blank, input, 4 bits: digit suppress per digit, 1 = digit dark.
REQ-009 The block SHALL have port seg, output, 7 bits [0:6], order a..g: segment cathodes, active-low.
REQ-010 The block SHALL have port an, output, 4 bits: digit anodes, active-low; an[i] selects digit i.
REQ-011 The block SHALL have port dp, output, 1 bit: decimal point cathode, active-low.
REQ-012 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at each frame wrap.

Function
REQ-013 The prescaler SHALL count 0..CLK_DIV-1 and wrap; the slot tick SHALL be the cycle where count = CLK_DIV-1.
REQ-014 The digit index idx (2 bits) SHALL advance 0→1→2→3→0 on each slot tick.
REQ-015 frame_done SHALL be high exactly in the cycle of the slot tick where idx = 3, and low otherwise.
REQ-016 Captured values SHALL go to a shadow register and set pending; the display register SHALL update only at the frame_done cycle, so a frame never mixes old and new data.
REQ-017 At the frame_done cycle with pending = 1, display SHALL take shadow and pending SHALL clear.
REQ-018 If load coincides with the frame_done cycle, display SHALL take the new input values directly and pending SHALL end at 0.
REQ-019 Repeated load before a frame boundary SHALL overwrite shadow; the last value wins.
REQ-020 an, seg and dp SHALL be combinational functions of the registered idx, count and display, with no path from load/digits.
REQ-021 During count < GUARD, or when display blank[idx] = 1: an = 1111, seg = 1111111, dp = 1.
REQ-022 Otherwise: an = 1110 rotated so bit idx = 0, seg = decode(nibble idx), dp = ~dp_in[idx].
REQ-023 The decode table (seg[0:6]) SHALL be:
- 0 0000001; 1 1001111; 2 0010010; 3 0000110
- 4 1001100; 5 0100100; 6 0100000; 7 0001111
- 8 0000000; 9 0000100; A 0001000; b 1100000
- C 0110001; d 1000010; E 0110000; F 0111000
REQ-024 At most one an bit SHALL be low in any cycle.

Reset
REQ-025 rst_n low SHALL immediately, without waiting for a clock edge, clear count, idx, shadow, display (digits 0, dp 0, blank 0), pending and frame_done.
REQ-026 During reset: an = 1111, seg = 1111111, dp = 1.
REQ-027 The first clk rising edge after rst_n goes high SHALL start counting at count = 0 in slot 0.
REQ-028 Reset asserted mid-frame or with pending = 1 SHALL discard the pending value; after release, display shows 0000 until the next load takes effect.

Verification
REQ-029 Release reset, no load, defaults → repeating 16-cycle frame:
- per slot, 1 cycle an = 1111, then 3 cycles an[idx] = 0 with seg = 0000001
- frame_done high once per 16 cycles, on cycle 15 of each frame.
REQ-030 load digits = 16'h4F9A, dp_in = 0000, blank = 0000 mid-frame → current frame still shows 0000; next frame slots 0..3 show:
- slot 0: seg = 0001000
- slot 1: seg = 0000100
- slot 2: seg = 0111000
- slot 3: seg = 1001100
REQ-031 load 16'h1111, then two cycles later load 16'h2222, same frame → next frame shows all 2 (seg = 0010010); 1 never displayed.
REQ-032 load 16'h0008, blank = 1110, dp_in = 0001, asserted on the frame_done cycle → next cycle begins a frame where:
- slot 0: an = 1110, seg = 0000000, dp = 0
- slots 1–3: an = 1111 throughout.
REQ-033 Assert rst_n low during slot 2 with pending = 1 → outputs go dark asynchronously; after release, display = 0000 and the pending value is never shown.
REQ-034 Over all runs, assert every cycle:
- an has at most one 0
- frame_done width = 1 cycle.
